// File: rtl/approx_mult_pkg.sv
// Shared types and constants for the approximate multiplier family.
// Latency: none (declarations only).
// Backpressure: not applicable.
package approx_mult_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;
  localparam int NIB_W = OP_W / 2;
  localparam int PP_W  = 2 * NIB_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [1:0] quad_idx_t;

  // Quadrant order: bit 0 selects the a nibble, bit 1 selects the b nibble.
  localparam quad_idx_t Q_LL = 2'd0;
  localparam quad_idx_t Q_HL = 2'd1;
  localparam quad_idx_t Q_LH = 2'd2;
  localparam quad_idx_t Q_HH = 2'd3;

  localparam logic [3:0] SHIFT_LL = 4'd0;
  localparam logic [3:0] SHIFT_HL = 4'd4;
  localparam logic [3:0] SHIFT_LH = 4'd4;
  localparam logic [3:0] SHIFT_HH = 4'd8;

  // Left shift that places a quadrant partial product in the 16-bit result.
  function automatic logic [3:0] quad_shift(input quad_idx_t q);
    logic [3:0] sh;
    case (q)
      Q_LL:    sh = SHIFT_LL;
      Q_HL:    sh = SHIFT_HL;
      Q_LH:    sh = SHIFT_LH;
      default: sh = SHIFT_HH;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/approx_4x4.sv
// Approximate 4x4 multiplier built from four Kulkarni 2x2 blocks, OR-merged.
// Latency: combinational, product valid in the same cycle as the operands.
// Backpressure: none; purely combinational.
module approx_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // Kulkarni 2x2: exact except 3x3, which yields 7 and so never needs bit 3.
  function automatic logic [3:0] mul2x2(input logic [1:0] x, input logic [1:0] w);
    return {1'b0, x[1] & w[1], (x[1] & w[0]) | (x[0] & w[1]), x[0] & w[0]};
  endfunction

  logic [3:0] pp_ll;
  logic [3:0] pp_hl;
  logic [3:0] pp_lh;
  logic [3:0] pp_hh;

  assign pp_ll = mul2x2(a[1:0], b[1:0]);
  assign pp_hl = mul2x2(a[3:2], b[1:0]);
  assign pp_lh = mul2x2(a[1:0], b[3:2]);
  assign pp_hh = mul2x2(a[3:2], b[3:2]);

  // Partials are merged with OR instead of an adder tree.
  assign p = {4'b0000, pp_ll}
           | {2'b00, pp_hl, 2'b00}
           | {2'b00, pp_lh, 2'b00}
           | {pp_hh, 4'b0000};

endmodule

// File: rtl/approx_8x8_seq.sv
// Approximate 8x8 multiplier time-sharing one approx_4x4 over four quadrant cycles.
// Latency: accept at edge T, y/out_valid visible after edge T+4; one op per 6 cycles max.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module approx_8x8_seq
  import approx_mult_pkg::*;
#(
  parameter bit COMBINE_OR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] y
);

  state_e           state;
  state_e           state_nxt;
  quad_idx_t        q;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] acc_nxt;
  logic [RES_W-1:0] pp_ext;
  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [PP_W-1:0]  pp;
  logic             accept;
  logic             last_quad;
  logic             out_hs;

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign last_quad = (state == MUL) && (q == Q_HH);
  assign out_hs    = (state == DONE) && out_ready;

  // Nibble select from the registered operands only, so late a/b changes are harmless.
  always_comb begin
    nib_a = q[0] ? op_a[OP_W-1:NIB_W] : op_a[NIB_W-1:0];
    nib_b = q[1] ? op_b[OP_W-1:NIB_W] : op_b[NIB_W-1:0];
  end

  approx_4x4 u_mul4 (
    .a (nib_a),
    .b (nib_b),
    .p (pp)
  );

  // Place the zero-extended partial and merge it into the running result.
  always_comb begin
    pp_ext  = RES_W'(pp) << quad_shift(q);
    acc_nxt = COMBINE_OR ? (acc | pp_ext) : (acc + pp_ext);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: accept -> four MUL cycles -> hold until drained.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = MUL;
      MUL:     if (q == Q_HH)  state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Operand capture, quadrant stepping, accumulation and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= Q_LL;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        op_a <= a;
        op_b <= b;
        acc  <= '0;
        q    <= Q_LL;
      end else if (state == MUL) begin
        acc <= acc_nxt;
        q   <= q + 2'd1;
      end

      if (last_quad) begin
        y         <= acc_nxt;
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_approx_8x8_seq.sv
// Self-checking bench for approx_8x8_seq, both accumulation modes side by side.
// Latency: checks accept-to-result of four cycles and single-cycle handshakes.
// Backpressure: exercises a held result with out_ready low and a stray in_valid.
module tb_approx_8x8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  a_drv;
  logic [7:0]  b_drv;
  logic        rdy0, rdy1;
  logic        ov0, ov1;
  logic [15:0] y0, y1;

  int checks = 0;
  int errors = 0;

  logic [15:0] q_add[$];
  logic [15:0] q_or[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y_add;
    logic [15:0] y_or;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  approx_8x8_seq #(.COMBINE_OR(1'b0)) dut_add (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .a(a_drv), .b(b_drv), .out_valid(ov0), .out_ready(out_ready), .y(y0)
  );

  approx_8x8_seq #(.COMBINE_OR(1'b1)) dut_or (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .a(a_drv), .b(b_drv), .out_valid(ov1), .out_ready(out_ready), .y(y1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: 2x2 is exact except 3*3 -> 7; 4x4 ORs its shifted 2x2 partials.
  function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] w);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        logic [1:0] xs, ws;
        logic [7:0] m;
        xs = x[2*i +: 2];
        ws = w[2*j +: 2];
        m  = (xs == 2'd3 && ws == 2'd3) ? 8'd7 : 8'(xs) * 8'(ws);
        r  = r | (m << (2 * (i + j)));
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] w, input bit use_or);
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        logic [15:0] part;
        part = 16'(ref4(x[4*i +: 4], w[4*j +: 4])) << (4 * (i + j));
        r = use_or ? (r | part) : (r + part);
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        input logic [15:0] ea, input logic [15:0] eo, input int stall);
    int n;
    logic [15:0] exp_a, exp_o;
    n = 0;
    while (!(rdy0 && rdy1) && n < 20) begin tick(); n++; end
    check("in_ready_idle", 32'(rdy0 & rdy1), 32'd1);
    out_ready = (stall == 0);
    a_drv = va;
    b_drv = vb;
    in_valid = 1'b1;
    q_add.push_back(ea);
    q_or.push_back(eo);
    tick();
    in_valid = 1'b0;
    a_drv = ~va;
    b_drv = vb ^ 8'hA5;
    check("in_ready_busy", 32'(rdy0 | rdy1), 32'd0);
    n = 0;
    while (!(ov0 || ov1) && n < 12) begin tick(); n++; end
    check("latency", 32'(n), 32'd4);
    check("out_valid_both", 32'({ov0, ov1}), 32'd3);
    exp_a = q_add.pop_front();
    exp_o = q_or.pop_front();
    check("y_add", 32'(y0), 32'(exp_a));
    check("y_or", 32'(y1), 32'(exp_o));
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        if (i == 3) begin in_valid = 1'b1; a_drv = 8'hFF; b_drv = 8'hFF; end
        if (i == 4) in_valid = 1'b0;
        tick();
        check("stall_out_valid", 32'(ov0 & ov1), 32'd1);
        check("stall_y_add", 32'(y0), 32'(exp_a));
        check("stall_y_or", 32'(y1), 32'(exp_o));
        check("stall_in_ready", 32'(rdy0 | rdy1), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    check("out_valid_dropped", 32'(ov0 | ov1), 32'd0);
    check("in_ready_back", 32'(rdy0 & rdy1), 32'd1);
    check("y_retained", 32'(y0), 32'(exp_a));
  endtask

  initial begin
    vecs[0]  = '{8'h02, 8'h03, 16'h0006, 16'h0006};
    vecs[1]  = '{8'h0F, 8'h03, 16'h001F, 16'h001F};
    vecs[2]  = '{8'hFF, 8'hFF, 16'h8F5F, 16'h7FFF};
    vecs[3]  = '{8'h10, 8'h10, 16'h0100, 16'h0100};
    vecs[4]  = '{8'h00, 8'hFF, 16'h0000, 16'h0000};
    vecs[5]  = '{8'h01, 8'h01, 16'h0001, 16'h0001};
    vecs[6]  = '{8'h11, 8'h11, 16'h0121, 16'h0111};
    vecs[7]  = '{8'h80, 8'h01, 16'h0080, 16'h0080};
    vecs[8]  = '{8'h01, 8'h80, 16'h0080, 16'h0080};
    vecs[9]  = '{8'h33, 8'h33, 16'h07E7, 16'h0777};
    vecs[10] = '{8'h22, 8'h22, 16'h0484, 16'h0444};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a_drv = 8'h00;
    b_drv = 8'h00;
    #1;
    check("in_ready_in_reset", 32'(rdy0 | rdy1), 32'd0);
    tick();
    tick();
    check("reset_out_valid", 32'(ov0 | ov1), 32'd0);
    check("reset_y_add", 32'(y0), 32'd0);
    check("reset_y_or", 32'(y1), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", 32'(rdy0 & rdy1), 32'd1);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].y_add, vecs[i].y_or, 0);

    run_op(8'h02, 8'h03, 16'h0006, 16'h0006, 10);
    run_op(8'h0F, 8'h03, 16'h001F, 16'h001F, 0);

    // Abort an FF*FF operation while quadrant 2 is in flight.
    out_ready = 1'b1;
    a_drv = 8'hFF;
    b_drv = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("in_ready_forced_low", 32'(rdy0 | rdy1), 32'd0);
    tick();
    rst = 1'b0;
    check("abort_out_valid", 32'(ov0 | ov1), 32'd0);
    check("abort_y_add", 32'(y0), 32'd0);
    check("abort_y_or", 32'(y1), 32'd0);
    #1;
    check("abort_in_ready", 32'(rdy0 & rdy1), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_result", 32'(ov0 | ov1), 32'd0);
    end
    run_op(8'h10, 8'h10, 16'h0100, 16'h0100, 0);

    for (int i = 0; i < 16; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, ref8(ra, rb, 1'b0), ref8(ra, rb, 1'b1), (i % 4 == 3) ? 2 : 0);
    end

    check("scoreboard_empty", 32'(q_add.size() + q_or.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
